miriscv_mdu_seq: RTL and testbench
==================================

# miriscv_mdu_seq

Multi-cycle sequencer for the RV32M multiply/divide unit in the execute stage. It accepts the decoded MDU request and funct3 operation, and stalls the pipeline while the operation runs. Multiplies use a registered single-cycle product. Divides use a 32-step restoring iteration, with a one-cycle fast path for the architectural special cases. The result returns on the MDU writeback source.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk_i  in  1  core clock; all state on rising edge.
- arstn_i  in  1  asynchronous active-low reset.
- mdu_req_i  in  1  decoded MDU request for the instruction in execute; held with operands while mdu_stall_req_o is high.
- mdu_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- mdu_port_a_i  in  XLEN  rs1 operand.
- mdu_port_b_i  in  XLEN  rs2 operand.
- mdu_kill_i  in  1  pipeline flush; aborts the current or incoming operation.
- mdu_stall_req_o  out  1  execute stage must hold.
- mdu_done_o  out  1  one-cycle pulse; mdu_result_o is valid.
- mdu_result_o  out  XLEN  result; holds its last value outside done.
- mdu_busy_o  out  1  FSM not in IDLE (debug/perf).

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset state is IDLE.
- IDLE, mdu_req_i=1, mdu_kill_i=0:
  - Latch op and operands.
  - Next state:
    - MUL for ops 0-3.
    - DONE for a divide fast case.
    - Otherwise DIV with step counter = 0.
- MUL:
  - 33x33 signed product. Operand sign extension per op: MULH both signed, MULHSU a signed/b unsigned, MULHU none, MUL don't care.
  - Result is the low word for MUL, the high word otherwise. Registered into the result register.
  - Next state: DONE.
- DIV:
  - Magnitudes are used for DIV/REM; raw values for DIVU/REMU.
  - One restoring step per cycle: shift remainder:dividend left, trial-subtract divisor, set quotient bit.
  - At counter = 31, sign-fix and write the result register; next state DONE.
  - Quotient is negated if the signed operand signs differ. Remainder takes the dividend's sign.
- Fast cases (decided in IDLE):
  - Divisor 0: quotient = 0xFFFFFFFF; remainder = dividend.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- DONE:
  - mdu_done_o=1, mdu_stall_req_o=0.
  - Next state IDLE unconditionally. The still-asserted mdu_req_i of the retiring instruction is ignored.
- mdu_stall_req_o = (IDLE & mdu_req_i & ~mdu_kill_i) | MUL | DIV. Combinational, so it stalls in the accept cycle.
- Kill:
  - mdu_kill_i=1 in any state forces IDLE next cycle.
  - mdu_stall_req_o and mdu_done_o are 0 in that cycle.
  - The result register is not updated.
  - A request in IDLE with kill is not accepted.

## Timing
- Reset values: mdu_stall_req_o 0, mdu_done_o 0, mdu_result_o 0, mdu_busy_o 0, state IDLE, counter 0.
- Latency counts from the accept cycle (cycle 0) to the mdu_done_o cycle:
  - MUL family: 2.
  - Divide: 33.
  - Divide fast case: 1.
- Stall cycles equal latency. The instruction advances at the end of the DONE cycle.
- Back-to-back MDU ops: the next request is sampled in the IDLE cycle after DONE. Throughput is 1 op per latency+1 cycles.
- Operands are sampled only in IDLE. Changes afterwards are ignored.
- Counter wraps only via the 31→DONE transition and never exceeds 31.
- Reset asserted mid-operation: asynchronous return to IDLE and all outputs to reset values in the same cycle. No done pulse follows.
- Kill and the DIV final step in the same cycle: kill wins; no result write, no done.

## Test plan
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB, done in cycle 2, stall high in cycles 0-1. Same operands with MULHU → 0x00000006.
- MULH a=b=0x80000000 → 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD, done in cycle 33. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14; REMU → 2.
- Fast cases, done in cycle 1:
  - DIVU a=0x1234, b=0 → 0xFFFFFFFF.
  - REM a=0x1234, b=0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Kill at DIV step 10 → stall low that cycle, no done, result register unchanged. The following MUL 3×5 returns 15 in 2 cycles.
- Drop arstn_i at DIV step 20 → all outputs 0 immediately. Then:
  - After release, an idle mdu_req_i=0 produces no done.
  - Two back-to-back MULs each return correctly, with one IDLE cycle between done pulses.

Source files
------------

// File: rtl/miriscv_mdu_seq_if.sv
// rtl/miriscv_mdu_seq_if.sv - execute-stage to MDU sequencer request/response bundle
interface miriscv_mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            mdu_req_i;
    logic [2:0]      mdu_op_i;
    logic [XLEN-1:0] mdu_port_a_i;
    logic [XLEN-1:0] mdu_port_b_i;
    logic            mdu_kill_i;
    logic            mdu_stall_req_o;
    logic            mdu_done_o;
    logic [XLEN-1:0] mdu_result_o;
    logic            mdu_busy_o;

    // Execute stage side: issues requests, observes stall/done/result.
    modport master (
        output mdu_req_i, mdu_op_i, mdu_port_a_i, mdu_port_b_i, mdu_kill_i,
        input  mdu_stall_req_o, mdu_done_o, mdu_result_o, mdu_busy_o
    );

    // Sequencer side.
    modport slave (
        input  mdu_req_i, mdu_op_i, mdu_port_a_i, mdu_port_b_i, mdu_kill_i,
        output mdu_stall_req_o, mdu_done_o, mdu_result_o, mdu_busy_o
    );
endinterface

// File: rtl/miriscv_mdu_seq.sv
// rtl/miriscv_mdu_seq.sv - RV32M multi-cycle multiply/divide sequencer
module miriscv_mdu_seq #(
    parameter int XLEN = 32
) (
    input logic             clk_i,
    input logic             arstn_i,
    miriscv_mdu_seq_if.slave mdu
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    // a_q: multiplicand, or dividend shifting out while quotient bits shift in
    logic [XLEN-1:0] a_q, a_d;
    // b_q: multiplier, or divisor magnitude
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            req_ok;
    logic            in_signed;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] fast_res;
    logic signed [XLEN:0]     mul_a, mul_b;
    logic signed [2*XLEN+1:0] prod;
    logic            unused_prod_hi;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            ge;
    logic [XLEN-1:0] rem_n, quo_n, q_fin, r_fin;

    // Operand preparation, datapath and next-state computation
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        req_ok    = mdu.mdu_req_i & ~mdu.mdu_kill_i;
        in_signed = ~mdu.mdu_op_i[0];
        abs_a     = (in_signed & mdu.mdu_port_a_i[XLEN-1]) ? -mdu.mdu_port_a_i : mdu.mdu_port_a_i;
        abs_b     = (in_signed & mdu.mdu_port_b_i[XLEN-1]) ? -mdu.mdu_port_b_i : mdu.mdu_port_b_i;
        div_zero  = (mdu.mdu_port_b_i == '0);
        div_ovf   = in_signed & (mdu.mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}})
                              & (mdu.mdu_port_b_i == '1);
        if (mdu.mdu_op_i[1]) begin
            fast_res = div_zero ? mdu.mdu_port_a_i : '0;
        end else begin
            fast_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        end

        // MULHU treats a as unsigned; only MUL/MULH treat b as signed
        mul_a = {(op_q != 3'd3) & a_q[XLEN-1], a_q};
        mul_b = {((op_q == 3'd0) || (op_q == 3'd1)) & b_q[XLEN-1], b_q};
        prod  = mul_a * mul_b;
        unused_prod_hi = ^prod[2*XLEN+1:2*XLEN];

        // One restoring step: remainder fits XLEN bits, shifted value XLEN+1
        rem_sh = {rem_q, a_q[XLEN-1]};
        diff   = {1'b0, rem_sh} - {2'b00, b_q};
        ge     = ~diff[XLEN+1];
        rem_n  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_n  = {a_q[XLEN-2:0], ge};
        q_fin  = q_neg_q ? -quo_n : quo_n;
        r_fin  = r_neg_q ? -rem_n : rem_n;

        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    op_d  = mdu.mdu_op_i;
                    a_d   = mdu.mdu_port_a_i;
                    b_d   = mdu.mdu_port_b_i;
                    cnt_d = '0;
                    if (!mdu.mdu_op_i[2]) begin
                        state_d = S_MUL;
                    end else if (div_zero || div_ovf) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end else begin
                        a_d     = abs_a;
                        b_d     = abs_b;
                        rem_d   = '0;
                        q_neg_d = in_signed & (mdu.mdu_port_a_i[XLEN-1] ^ mdu.mdu_port_b_i[XLEN-1]);
                        r_neg_d = in_signed & mdu.mdu_port_a_i[XLEN-1];
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                result_d = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                state_d  = S_DONE;
            end
            S_DIV: begin
                rem_d = rem_n;
                a_d   = quo_n;
                if (cnt_q == 5'd31) begin
                    result_d = op_q[1] ? r_fin : q_fin;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over everything, including the final divide step
        if (mdu.mdu_kill_i) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    // Stall is combinational so the accept cycle already holds the pipeline
    assign mdu.mdu_stall_req_o = arstn_i & ~mdu.mdu_kill_i &
                                 (((state_q == S_IDLE) & mdu.mdu_req_i) |
                                  (state_q == S_MUL) | (state_q == S_DIV));
    assign mdu.mdu_done_o      = (state_q == S_DONE) & ~mdu.mdu_kill_i;
    assign mdu.mdu_result_o    = result_q;
    assign mdu.mdu_busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_miriscv_mdu_seq.sv
// tb/tb_miriscv_mdu_seq.sv - directed self-checking bench for miriscv_mdu_seq
module tb_miriscv_mdu_seq;
    logic clk_i   = 1'b0;
    logic arstn_i = 1'b0;
    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   done1_cyc;
    int   done2_cyc;
    int   pulses;

    always #5 clk_i = ~clk_i;

    // Free-running cycle count for done-to-done spacing
    always @(posedge clk_i) cyc <= cyc + 1;

    miriscv_mdu_seq_if ifc ();

    miriscv_mdu_seq dut (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .mdu     (ifc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one op in the current IDLE cycle and follow it to its done pulse
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         output int done_at);
        int n;
        bit stall_ok;
        ifc.mdu_req_i    = 1'b1;
        ifc.mdu_op_i     = op;
        ifc.mdu_port_a_i = a;
        ifc.mdu_port_b_i = b;
        #1;
        chk({tag, "_stall_accept"}, {31'd0, ifc.mdu_stall_req_o}, 32'd1);
        n        = 0;
        stall_ok = 1'b1;
        while (n < 100) begin
            tick();
            n++;
            ifc.mdu_port_a_i = $urandom;
            ifc.mdu_port_b_i = $urandom;
            #1;
            if (ifc.mdu_done_o) break;
            if (!ifc.mdu_stall_req_o) stall_ok = 1'b0;
        end
        done_at = cyc;
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_result"}, ifc.mdu_result_o, exp);
        chk({tag, "_stall_held"}, {31'd0, stall_ok}, 32'd1);
        chk({tag, "_stall_done"}, {31'd0, ifc.mdu_stall_req_o}, 32'd0);
        tick();
        ifc.mdu_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        ifc.mdu_req_i    = 1'b0;
        ifc.mdu_op_i     = 3'd0;
        ifc.mdu_port_a_i = '0;
        ifc.mdu_port_b_i = '0;
        ifc.mdu_kill_i   = 1'b0;
        tick();
        tick();
        chk("rst_stall",  {31'd0, ifc.mdu_stall_req_o}, 32'd0);
        chk("rst_done",   {31'd0, ifc.mdu_done_o}, 32'd0);
        chk("rst_result", ifc.mdu_result_o, 32'd0);
        chk("rst_busy",   {31'd0, ifc.mdu_busy_o}, 32'd0);
        arstn_i = 1'b1;
        tick();

        do_op("mul",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2,  d);
        do_op("mulhu",    3'd3, 32'd7,        32'hFFFFFFFD, 32'h00000006, 2,  d);
        do_op("mulh",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 2,  d);
        do_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  d);
        do_op("div",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, d);
        do_op("rem",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, d);
        do_op("divu",     3'd5, 32'd100,      32'd7,        32'd14,       33, d);
        do_op("remu",     3'd7, 32'd100,      32'd7,        32'd2,        33, d);
        do_op("divu_z",   3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF, 1,  d);
        do_op("rem_z",    3'd6, 32'h1234,     32'd0,        32'h00001234, 1,  d);
        do_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  d);
        do_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  d);
        do_op("remu_b",   3'd7, 32'd100,      32'd7,        32'd2,        33, d);

        // Kill at divide step 10 (cycle 11 after accept)
        ifc.mdu_req_i    = 1'b1;
        ifc.mdu_op_i     = 3'd5;
        ifc.mdu_port_a_i = 32'd1000;
        ifc.mdu_port_b_i = 32'd3;
        for (int i = 0; i < 11; i++) tick();
        chk("kill_busy_before", {31'd0, ifc.mdu_busy_o}, 32'd1);
        chk("kill_stall_before", {31'd0, ifc.mdu_stall_req_o}, 32'd1);
        ifc.mdu_kill_i = 1'b1;
        #1;
        chk("kill_stall", {31'd0, ifc.mdu_stall_req_o}, 32'd0);
        chk("kill_done",  {31'd0, ifc.mdu_done_o}, 32'd0);
        tick();
        ifc.mdu_kill_i = 1'b0;
        ifc.mdu_req_i  = 1'b0;
        #1;
        chk("kill_busy_after", {31'd0, ifc.mdu_busy_o}, 32'd0);
        chk("kill_result_kept", ifc.mdu_result_o, 32'd2);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifc.mdu_done_o) pulses++;
        end
        chk("kill_no_done", pulses, 0);
        do_op("mul_after_kill", 3'd0, 32'd3, 32'd5, 32'd15, 2, d);

        // Asynchronous reset at divide step 20 (cycle 21 after accept)
        ifc.mdu_req_i    = 1'b1;
        ifc.mdu_op_i     = 3'd4;
        ifc.mdu_port_a_i = 32'hFFFFFFF9;
        ifc.mdu_port_b_i = 32'd2;
        for (int i = 0; i < 21; i++) tick();
        chk("arst_busy_before", {31'd0, ifc.mdu_busy_o}, 32'd1);
        #2;
        arstn_i = 1'b0;
        #1;
        chk("arst_stall",  {31'd0, ifc.mdu_stall_req_o}, 32'd0);
        chk("arst_done",   {31'd0, ifc.mdu_done_o}, 32'd0);
        chk("arst_result", ifc.mdu_result_o, 32'd0);
        chk("arst_busy",   {31'd0, ifc.mdu_busy_o}, 32'd0);
        ifc.mdu_req_i = 1'b0;
        tick();
        arstn_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ifc.mdu_done_o) pulses++;
        end
        chk("idle_no_done", pulses, 0);

        do_op("b2b_mul1", 3'd0, 32'd6,        32'd7,        32'd42,       2, done1_cyc);
        do_op("b2b_mul2", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, done2_cyc);
        chk("b2b_spacing", done2_cyc - done1_cyc, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
